// File: rtl/alu_vector_driver.sv
// Sequential stimulus driver for ALU32: accepts one operand vector per handshake, waits a
// fixed settle time, captures the ALU result and presents it on a valid/ready result port.
// Optional expected-value compare enabled by defining ALU_EXPECT_CHECK_EN.
module alu_vector_driver #(
  parameter int WIDTH   = 32,
  parameter int OPWIDTH = 4,
  parameter int SETTLE  = 2,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [WIDTH-1:0]   vec_in1,
  input  logic [WIDTH-1:0]   vec_in2,
  input  logic [OPWIDTH-1:0] vec_op,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic [OPWIDTH-1:0] alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic [OPWIDTH-1:0] res_op,
  output logic [CNTW-1:0]    vec_count,
  output logic               busy
`ifdef ALU_EXPECT_CHECK_EN
  ,
  input  logic [WIDTH-1:0]   vec_exp,
  output logic               res_mismatch,
  output logic [CNTW-1:0]    err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [7:0] cnt_reg;
  logic       accept;
  logic       capture;
  logic       done;

  // Outputs decoded straight from the state register so an async reset drops them at once.
  assign vec_ready = (state_reg == ST_IDLE);
  assign busy      = !vec_ready;
  assign res_valid = (state_reg == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (vec_valid) begin
          accept     = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == 8'd0) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Settle counter is loaded with SETTLE-1 so capture lands exactly SETTLE edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 8'd0;
    end else if (accept) begin
      cnt_reg <= 8'(SETTLE - 1);
    end else if (state_reg == ST_SETTLE && cnt_reg != 8'd0) begin
      cnt_reg <= cnt_reg - 8'd1;
    end
  end

  // ALU operands keep the last applied vector after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op  <= '0;
    end else if (accept) begin
      alu_in1 <= vec_in1;
      alu_in2 <= vec_in2;
      alu_op  <= vec_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_op   <= '0;
    end else if (capture) begin
      res_data <= alu_out;
      res_op   <= alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count <= '0;
    end else if (done) begin
      vec_count <= vec_count + CNTW'(1);
    end
  end

`ifdef ALU_EXPECT_CHECK_EN
  logic [WIDTH-1:0] exp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_reg      <= '0;
      res_mismatch <= 1'b0;
    end else begin
      if (accept) begin
        exp_reg <= vec_exp;
      end
      if (capture) begin
        res_mismatch <= (alu_out != exp_reg);
      end
    end
  end

  // Error counter saturates rather than wrapping so a long run never hides failures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (done && res_mismatch && err_count != {CNTW{1'b1}}) begin
      err_count <= err_count + CNTW'(1);
    end
  end
`endif

endmodule
